// File: rtl/meas_seq_stacked.sv
// Measurement sequencer for the stacked odometer power-enable control set:
// stress -> settle -> timed ROSC window -> result hold -> glitch-free release.
module meas_seq_stacked #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int ITER_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MEAS_REQ,
  input  logic              CONT,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  STRESS_LEN,
  input  logic [CNT_W-1:0]  MEAS_LEN,
  input  logic              RESULT_ACK,
  output logic              START,
  output logic              MEAS_STRESS,
  output logic              MEAS_DONE,
  output logic              RESULT_VLD,
  output logic              BUSY,
  output logic [ITER_W-1:0] ITER_CNT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STRESS  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEAS    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abrt_q, abrt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              arm;

  logic start_q, mstress_q, mdone_q, vld_q, busy_q;
  logic start_d, mstress_d, mdone_d, vld_d, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abrt_d  = abrt_q;
    iter_d  = iter_q;
    arm     = 1'b0;
    case (state_q)
      S_IDLE: arm = MEAS_REQ;
      S_STRESS, S_SETTLE, S_MEAS: begin
        if (ABORT) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          abrt_d  = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (state_q == S_STRESS) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if (state_q == S_SETTLE) begin
          state_d = S_MEAS;
          cnt_d   = (MEAS_LEN == '0) ? '0 : MEAS_LEN - CNT_ONE;
        end else begin
          state_d = S_HOLD;
          iter_d  = (iter_q == '1) ? iter_q : iter_q + ITER_W'(1);
        end
      end
      S_HOLD: begin
        // ABORT outranks RESULT_ACK so an aborted hold never re-arms
        if (ABORT) begin
          state_d = S_RELEASE;
          abrt_d  = 1'b1;
        end else if (RESULT_ACK) begin
          state_d = S_RELEASE;
          abrt_d  = 1'b0;
        end
      end
      S_RELEASE: begin
        if (CONT && !abrt_q) arm = 1'b1;
        else                 state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (arm) begin
      abrt_d = 1'b0;
      if (STRESS_LEN == '0) begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end else begin
        state_d = S_STRESS;
        cnt_d   = STRESS_LEN - CNT_ONE;
      end
    end
  end

  // Outputs are decoded from the next state and registered, so every
  // output changes only at a clock edge.
  always_comb begin
    start_d   = 1'b0;
    mstress_d = 1'b0;
    mdone_d   = 1'b0;
    vld_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_STRESS:  start_d = 1'b1;
      S_SETTLE:  begin mstress_d = 1'b1; mdone_d = 1'b1; end
      S_MEAS:    mstress_d = 1'b1;
      S_HOLD:    begin mstress_d = 1'b1; mdone_d = 1'b1; vld_d = 1'b1; end
      S_RELEASE: mdone_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      abrt_q    <= 1'b0;
      iter_q    <= '0;
      start_q   <= 1'b0;
      mstress_q <= 1'b0;
      mdone_q   <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abrt_q    <= abrt_d;
      iter_q    <= iter_d;
      start_q   <= start_d;
      mstress_q <= mstress_d;
      mdone_q   <= mdone_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
    end
  end

  assign START       = start_q;
  assign MEAS_STRESS = mstress_q;
  assign MEAS_DONE   = mdone_q;
  assign RESULT_VLD  = vld_q;
  assign BUSY        = busy_q;
  assign ITER_CNT    = iter_q;

endmodule

// File: tb/tb_meas_seq_stacked.sv
// Scoreboard bench for meas_seq_stacked: a phase-level model expands each
// request into per-cycle expected outputs that a monitor compares.
module tb_meas_seq_stacked;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, MEAS_REQ, CONT, ABORT, RESULT_ACK;
  logic [15:0] STRESS_LEN, MEAS_LEN;
  logic        start_a, ms_a, md_a, vld_a, busy_a;
  logic [7:0]  it_a;
  logic        start_b, ms_b, md_b, vld_b, busy_b;
  logic [1:0]  it_b;

  meas_seq_stacked #(.CNT_W(16), .SETTLE_CYC(8), .ITER_W(8)) u_dut (
    .CLK(CLK), .RESET(RESET), .MEAS_REQ(MEAS_REQ), .CONT(CONT), .ABORT(ABORT),
    .STRESS_LEN(STRESS_LEN), .MEAS_LEN(MEAS_LEN), .RESULT_ACK(RESULT_ACK),
    .START(start_a), .MEAS_STRESS(ms_a), .MEAS_DONE(md_a),
    .RESULT_VLD(vld_a), .BUSY(busy_a), .ITER_CNT(it_a));

  meas_seq_stacked #(.CNT_W(16), .SETTLE_CYC(8), .ITER_W(2)) u_sat (
    .CLK(CLK), .RESET(RESET), .MEAS_REQ(MEAS_REQ), .CONT(CONT), .ABORT(ABORT),
    .STRESS_LEN(STRESS_LEN), .MEAS_LEN(MEAS_LEN), .RESULT_ACK(RESULT_ACK),
    .START(start_b), .MEAS_STRESS(ms_b), .MEAS_DONE(md_b),
    .RESULT_VLD(vld_b), .BUSY(busy_b), .ITER_CNT(it_b));

  localparam int SETTLE = 8;

  typedef struct packed {
    logic [2:0] ctl;
    logic       vld;
    logic       busy;
    logic [7:0] it8;
    logic [1:0] it2;
  } exp_t;

  typedef struct packed {
    logic        rst, req, cont, abort, ack;
    logic [15:0] slen, mlen;
  } stim_t;

  exp_t  sb[$];
  exp_t  te[$];
  stim_t ts[$];
  int checks = 0;
  int errors = 0;
  int m_it8 = 0;
  int m_it2 = 0;
  int win_L[300], win_M[300], win_D[300];
  int ab_kind, ab_w, ab_phase, ab_off;

  // Phase 0..5 = idle, stress, settle, meas, hold, release
  function automatic exp_t mk(input int ph);
    exp_t e;
    e.vld  = 1'b0;
    e.busy = (ph != 0);
    case (ph)
      1: e.ctl = 3'b100;
      2: e.ctl = 3'b011;
      3: e.ctl = 3'b010;
      4: begin e.ctl = 3'b011; e.vld = 1'b1; end
      5: e.ctl = 3'b001;
      default: e.ctl = 3'b000;
    endcase
    e.it8 = 8'(m_it8);
    e.it2 = 2'(m_it2);
    return e;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst   = 1'b0;
    s.req   = 1'($urandom);
    s.cont  = 1'($urandom);
    s.abort = 1'b0;
    s.ack   = 1'($urandom);
    s.slen  = 16'($urandom);
    s.mlen  = 16'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    RESET      = s.rst;
    MEAS_REQ   = s.req;
    CONT       = s.cont;
    ABORT      = s.abort;
    RESULT_ACK = s.ack;
    STRESS_LEN = s.slen;
    MEAS_LEN   = s.mlen;
  endtask

  task automatic run_txn(input int nw);
    stim_t s;
    bit    rst_hit, stop, aborted;
    int    n;
    te.delete();
    ts.delete();
    rst_hit = 0;
    stop    = 0;
    s = rnd_stim();
    s.req  = 1'b1;
    s.slen = 16'(win_L[0]);
    te.push_back(mk(0));
    ts.push_back(s);
    for (int w = 0; w < nw && !rst_hit && !stop; w++) begin
      aborted = 0;
      for (int ph = 1; ph <= 4 && !aborted && !rst_hit; ph++) begin
        n = (ph == 1) ? win_L[w] : (ph == 2) ? SETTLE :
            (ph == 3) ? ((win_M[w] == 0) ? 1 : win_M[w]) : win_D[w] + 1;
        if (ph == 4) begin
          if (m_it8 < 255) m_it8++;
          if (m_it2 < 3) m_it2++;
        end
        for (int j = 0; j < n; j++) begin
          s = rnd_stim();
          if (ph == 4) s.ack = (j == n - 1);
          if (ph == 2 && j == n - 1) s.mlen = 16'(win_M[w]);
          te.push_back(mk(ph));
          if (ab_kind != 0 && w == ab_w && ph == ab_phase && j == ab_off) begin
            if (ab_kind == 1) begin s.abort = 1'b1; s.ack = 1'($urandom); aborted = 1; end
            else begin s.rst = 1'b1; rst_hit = 1; end
          end
          ts.push_back(s);
          if (aborted || rst_hit) break;
        end
      end
      if (!rst_hit) begin
        s = rnd_stim();
        s.abort = 1'($urandom);
        if (!aborted) begin
          s.cont = (w < nw - 1);
          if (s.cont) s.slen = 16'(win_L[w + 1]);
        end
        te.push_back(mk(5));
        if (ab_kind == 2 && w == ab_w && ab_phase == 5) begin s.rst = 1'b1; rst_hit = 1; end
        ts.push_back(s);
        if (aborted) stop = 1;
      end
    end
    if (rst_hit) begin
      m_it8 = 0;
      m_it2 = 0;
    end else begin
      s = rnd_stim();
      s.req = 1'b0;
      te.push_back(mk(0));
      ts.push_back(s);
    end
    for (int i = 0; i < te.size(); i++) begin
      @(posedge CLK);
      #1;
      sb.push_back(te[i]);
      apply(ts[i]);
    end
  endtask

  task automatic set_win(input int w, input int l, input int m, input int d);
    win_L[w] = l;
    win_M[w] = m;
    win_D[w] = d;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({start_a, ms_a, md_a, vld_a, busy_a, it_a} !== {e.ctl, e.vld, e.busy, e.it8}) begin
          errors++;
          $display("FAIL main_vec @%0t: got ctl=%b vld=%b busy=%b iter=%0d, want ctl=%b vld=%b busy=%b iter=%0d",
                   $time, {start_a, ms_a, md_a}, vld_a, busy_a, it_a, e.ctl, e.vld, e.busy, e.it8);
        end
        checks++;
        if ({start_b, ms_b, md_b, vld_b, busy_b, it_b} !== {e.ctl, e.vld, e.busy, e.it2}) begin
          errors++;
          $display("FAIL sat_vec @%0t: got ctl=%b vld=%b busy=%b iter=%0d, want ctl=%b vld=%b busy=%b iter=%0d",
                   $time, {start_b, ms_b, md_b}, vld_b, busy_b, it_b, e.ctl, e.vld, e.busy, e.it2);
        end
      end else begin
        checks++;
        if ({busy_a, busy_b} !== 2'b00) begin
          errors++;
          $display("FAIL idle_busy @%0t: got busy=%b%b, want 00", $time, busy_a, busy_b);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    int nw;
    RESET = 1'b1; MEAS_REQ = 1'b0; CONT = 1'b0; ABORT = 1'b0; RESULT_ACK = 1'b0;
    STRESS_LEN = '0; MEAS_LEN = '0;
    repeat (2) @(posedge CLK);

    ab_kind = 0; ab_w = 0; ab_phase = 0; ab_off = 0;
    set_win(0, 5, 10, 2);  run_txn(1);
    set_win(0, 0, 0, 0);   run_txn(1);
    ab_kind = 1; ab_w = 0; ab_phase = 3; ab_off = 2;
    set_win(0, 3, 6, 1);   run_txn(1);
    ab_kind = 0;
    set_win(0, 2, 3, 1); set_win(1, 0, 1, 0); set_win(2, 4, 0, 2);
    run_txn(3);
    ab_kind = 2; ab_w = 0; ab_phase = 2; ab_off = 4;
    set_win(0, 3, 2, 0);   run_txn(1);
    ab_kind = 0;
    set_win(0, 40, 3, 0);  run_txn(1);

    for (int t = 0; t < 80; t++) begin
      int r;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++)
        set_win(w, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
      r = $urandom_range(0, 7);
      ab_kind  = (r < 5) ? 0 : (r < 7) ? 1 : 2;
      ab_w     = $urandom_range(0, nw - 1);
      ab_phase = (ab_kind == 2) ? $urandom_range(1, 5) : $urandom_range(1, 4);
      ab_off   = $urandom_range(0, 7);
      run_txn(nw);
    end

    ab_kind = 0;
    for (int w = 0; w < 261; w++) set_win(w, 0, 0, 0);
    run_txn(260);
    set_win(0, 1, 2, 1);   run_txn(1);

    repeat (3) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
